// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus launch sequencer in front of a UART byte transmitter.
// Optional sticky overflow flag enabled by defining UART_FEEDER_OVF_EN.
module uart_tx_feeder #(
    parameter int DEPTH_LOG2 = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [7:0]            i_wr_data,
    input  logic                  i_wr_en,
    output logic                  o_full,
    output logic [DEPTH_LOG2:0]   o_fifo_cnt,
    output logic                  o_overflow,
    input  logic                  i_ovf_clr,
    output logic [7:0]            o_data_byte,
    output logic                  o_send_en,
    input  logic                  i_tx_done,
    input  logic                  i_uart_state,
    output logic                  o_busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    // Only meaningful when GAP_CYCLES > 0; the GAP state is unreachable otherwise.
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_GAP
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_cnt;
    logic [7:0]            r_gap_cnt;
    logic [7:0]            r_data_byte;
    logic                  r_send_en;
    logic                  w_full;
    logic                  w_wr_acc;
    logic                  w_pop;
    logic                  w_load;

    assign w_full   = r_cnt[DEPTH_LOG2];
    assign w_wr_acc = i_wr_en & ~w_full;
    assign w_pop    = (r_state == S_LAUNCH);

    always_ff @(posedge i_clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_acc, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if ((r_cnt != '0) && !i_uart_state) begin
                    w_state_next = S_LAUNCH;
                    w_load       = 1'b1;
                end
            end
            S_LAUNCH: w_state_next = S_WAIT;
            S_WAIT: begin
                if (i_tx_done) begin
                    w_state_next = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Byte and strobe are loaded on the edge entering LAUNCH so they are
    // visible during the LAUNCH cycle itself; the head is popped at its end.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_gap_cnt   <= '0;
            r_data_byte <= 8'h00;
            r_send_en   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_send_en <= w_load;
            if (w_load) begin
                r_data_byte <= r_mem[r_rd_ptr];
            end
            if ((r_state == S_GAP) && (r_gap_cnt != GAP_LAST)) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

`ifdef UART_FEEDER_OVF_EN
    logic r_overflow;

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overflow <= 1'b0;
        end else if (i_wr_en && w_full) begin
            r_overflow <= 1'b1;
        end else if (i_ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign o_overflow = r_overflow;
`else
    logic w_unused_ovf_clr;
    assign w_unused_ovf_clr = i_ovf_clr;
    assign o_overflow       = 1'b0;
`endif

    assign o_full      = w_full;
    assign o_fifo_cnt  = r_cnt;
    assign o_data_byte = r_data_byte;
    assign o_send_en   = r_send_en;
    assign o_busy      = (r_state != S_IDLE) || (r_cnt != '0);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: cycle table for single launches plus
// hand-written burst, fill/overflow, pointer-wrap and mid-transfer reset runs.
module tb_uart_tx_feeder;

    localparam int DL    = 4;
    localparam int DEPTH = 1 << DL;
    localparam int GAP   = 2;
`ifdef UART_FEEDER_OVF_EN
    localparam int OVF_ON = 1;
`else
    localparam int OVF_ON = 0;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b1;
    logic [7:0]    i_wr_data = 8'h00;
    logic          i_wr_en = 1'b0;
    logic          i_ovf_clr = 1'b0;
    logic          i_tx_done = 1'b0;
    logic          i_uart_state = 1'b0;
    logic          o_full;
    logic [DL:0]   o_fifo_cnt;
    logic          o_overflow;
    logic [7:0]    o_data_byte;
    logic          o_send_en;
    logic          o_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] wq[$];
    logic [7:0] eq[$];

    typedef struct {
        logic       wr_en;
        logic [7:0] wr_data;
        logic       tx_done;
        logic       uart_state;
        logic [7:0] exp_db;
        logic       exp_send;
        int         exp_cnt;
        logic       exp_busy;
    } vec_t;

    vec_t tbl[15];

    uart_tx_feeder #(.DEPTH_LOG2(DL), .GAP_CYCLES(GAP)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_wr_data    (i_wr_data),
        .i_wr_en      (i_wr_en),
        .o_full       (o_full),
        .o_fifo_cnt   (o_fifo_cnt),
        .o_overflow   (o_overflow),
        .i_ovf_clr    (i_ovf_clr),
        .o_data_byte  (o_data_byte),
        .o_send_en    (o_send_en),
        .i_tx_done    (i_tx_done),
        .i_uart_state (i_uart_state),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    function automatic vec_t mk(input logic we, input logic [7:0] wd, input logic td,
                                input logic us, input logic es, input logic [7:0] edb,
                                input int ec, input logic eb);
        vec_t v;
        v.wr_en = we; v.wr_data = wd; v.tx_done = td; v.uart_state = us;
        v.exp_send = es; v.exp_db = edb; v.exp_cnt = ec; v.exp_busy = eb;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_full"}, int'(o_full), 0);
        chk({tag, "_cnt"}, int'(o_fifo_cnt), 0);
        chk({tag, "_ovf"}, int'(o_overflow), 0);
        chk({tag, "_db"}, int'(o_data_byte), 0);
        chk({tag, "_send"}, int'(o_send_en), 0);
        chk({tag, "_busy"}, int'(o_busy), 0);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (o_busy && n < 60) begin
            step();
            n++;
        end
        chk({tag, "_idle_timeout"}, int'(o_busy), 0);
    endtask

    // Transmitter model: tx_done 20 cycles after each send_en, busy meanwhile.
    task automatic run_tx(input string tag, input int n, input int init_cd, input int max_cyc);
        int   cd = init_cd;
        int   last_done = -1;
        int   got = 0;
        int   c = 0;
        logic prev_send = 1'b0;
        while ((got < n || cd > 0) && c < max_cyc) begin
            i_tx_done    = (cd == 1);
            i_uart_state = (cd > 0);
            if (cd == 1) last_done = cyc;
            if (cd > 0) cd--;
            if (wq.size() > 0 && o_fifo_cnt < DL'(DEPTH - 1)) begin
                i_wr_en   = 1'b1;
                i_wr_data = wq.pop_front();
            end else begin
                i_wr_en = 1'b0;
            end
            step();
            c++;
            if (o_send_en) begin
                chk({tag, "_no_double_send"}, int'(prev_send), 0);
                if (eq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL %s_extra_launch cyc=%0d actual=%0h required=none", tag, cyc, o_data_byte);
                end else begin
                    chk({tag, "_data"}, int'(o_data_byte), int'(eq.pop_front()));
                end
                if (last_done >= 0) chk({tag, "_spacing"}, cyc - last_done, GAP + 2);
                $display("%s launch %0d byte=%02h cyc=%0d", tag, got, o_data_byte, cyc);
                cd = 20;
                got++;
            end
            prev_send = o_send_en;
        end
        i_wr_en = 1'b0;
        i_tx_done = 1'b0;
        i_uart_state = 1'b0;
        chk({tag, "_launch_count"}, got, n);
        chk({tag, "_expect_left"}, eq.size(), 0);
    endtask

    initial begin
        int sends;

        tbl[0]  = mk(1, 8'hA5, 0, 0, 0, 8'h00, 1, 1);
        tbl[1]  = mk(0, 8'h00, 0, 0, 1, 8'hA5, 1, 1);
        tbl[2]  = mk(0, 8'h00, 0, 0, 0, 8'hA5, 0, 1);
        tbl[3]  = mk(0, 8'h00, 0, 0, 0, 8'hA5, 0, 1);
        tbl[4]  = mk(0, 8'h00, 1, 0, 0, 8'hA5, 0, 1);
        tbl[5]  = mk(0, 8'h00, 0, 0, 0, 8'hA5, 0, 1);
        tbl[6]  = mk(0, 8'h00, 0, 0, 0, 8'hA5, 0, 0);
        tbl[7]  = mk(0, 8'h00, 1, 0, 0, 8'hA5, 0, 0);
        tbl[8]  = mk(1, 8'h3C, 0, 1, 0, 8'hA5, 1, 1);
        tbl[9]  = mk(0, 8'h00, 0, 1, 0, 8'hA5, 1, 1);
        tbl[10] = mk(0, 8'h00, 0, 0, 1, 8'h3C, 1, 1);
        tbl[11] = mk(0, 8'h00, 0, 0, 0, 8'h3C, 0, 1);
        tbl[12] = mk(0, 8'h00, 1, 0, 0, 8'h3C, 0, 1);
        tbl[13] = mk(0, 8'h00, 0, 0, 0, 8'h3C, 0, 1);
        tbl[14] = mk(0, 8'h00, 0, 0, 0, 8'h3C, 0, 0);

        #1 i_rst_n = 1'b0;
        #11;
        chk_reset_vals("por");
        step();
        i_rst_n = 1'b1;
        step();

        for (int i = 0; i < 15; i++) begin
            i_wr_en      = tbl[i].wr_en;
            i_wr_data    = tbl[i].wr_data;
            i_tx_done    = tbl[i].tx_done;
            i_uart_state = tbl[i].uart_state;
            step();
            $display("vec %0d send=%0b db=%02h cnt=%0d busy=%0b", i, o_send_en, o_data_byte, o_fifo_cnt, o_busy);
            chk($sformatf("vec%0d_send", i), int'(o_send_en), int'(tbl[i].exp_send));
            chk($sformatf("vec%0d_db", i), int'(o_data_byte), int'(tbl[i].exp_db));
            chk($sformatf("vec%0d_cnt", i), int'(o_fifo_cnt), tbl[i].exp_cnt);
            chk($sformatf("vec%0d_busy", i), int'(o_busy), int'(tbl[i].exp_busy));
        end
        i_wr_en = 1'b0; i_tx_done = 1'b0; i_uart_state = 1'b0;

        wq = '{8'h01, 8'h02, 8'h03};
        eq = '{8'h01, 8'h02, 8'h03};
        run_tx("burst", 3, 0, 400);
        wait_idle("burst");

        // Fill with the transmitter reporting busy so nothing launches.
        i_uart_state = 1'b1;
        for (int i = 0; i < 17; i++) begin
            i_wr_en   = 1'b1;
            i_wr_data = 8'(8'h40 + i);
            step();
            $display("fill %0d cnt=%0d full=%0b ovf=%0b", i, o_fifo_cnt, o_full, o_overflow);
            if (i == 15) begin
                chk("fill16_cnt", int'(o_fifo_cnt), 16);
                chk("fill16_full", int'(o_full), 1);
                chk("fill16_ovf", int'(o_overflow), 0);
            end
        end
        chk("fill17_cnt", int'(o_fifo_cnt), 16);
        chk("fill17_full", int'(o_full), 1);
        chk("fill17_ovf", int'(o_overflow), OVF_ON);
        i_wr_data = 8'h52;
        i_ovf_clr = 1'b1;
        step();
        chk("ovf_clr_vs_drop", int'(o_overflow), OVF_ON);
        i_wr_en = 1'b0;
        step();
        chk("ovf_clr", int'(o_overflow), 0);
        i_ovf_clr = 1'b0;

        i_uart_state = 1'b0;
        step();
        chk("fullpop_send", int'(o_send_en), 1);
        chk("fullpop_db", int'(o_data_byte), 8'h40);
        chk("fullpop_full", int'(o_full), 1);
        i_wr_en   = 1'b1;
        i_wr_data = 8'h51;
        step();
        i_wr_en = 1'b0;
        $display("fullpop cnt=%0d full=%0b", o_fifo_cnt, o_full);
        chk("fullpop_cnt", int'(o_fifo_cnt), 15);
        chk("fullpop_full_after", int'(o_full), 0);
        eq.delete();
        for (int i = 1; i < 16; i++) eq.push_back(8'(8'h40 + i));
        run_tx("drain", 15, 20, 600);
        wait_idle("drain");
        chk("drain_cnt", int'(o_fifo_cnt), 0);

        wq.delete();
        eq.delete();
        for (int i = 0; i < 40; i++) begin
            wq.push_back(8'(i));
            eq.push_back(8'(i));
        end
        run_tx("wrap", 40, 0, 2000);
        wait_idle("wrap");

        for (int i = 0; i < 6; i++) begin
            i_wr_en   = 1'b1;
            i_wr_data = 8'(8'h90 + i);
            step();
        end
        i_wr_en = 1'b0;
        chk("pre_rst_cnt", int'(o_fifo_cnt), 5);
        chk("pre_rst_db", int'(o_data_byte), 8'h90);
        #2 i_rst_n = 1'b0;
        #1;
        $display("midrst cnt=%0d busy=%0b db=%02h", o_fifo_cnt, o_busy, o_data_byte);
        chk_reset_vals("midrst");
        step();
        step();
        i_rst_n = 1'b1;
        sends = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (o_send_en) sends++;
        end
        chk("post_rst_no_send", sends, 0);
        chk("post_rst_busy", int'(o_busy), 0);

        i_wr_en   = 1'b1;
        i_wr_data = 8'h77;
        step();
        i_wr_en = 1'b0;
        chk("lat_k1_send", int'(o_send_en), 0);
        step();
        $display("lat send=%0b db=%02h", o_send_en, o_data_byte);
        chk("lat_k2_send", int'(o_send_en), 1);
        chk("lat_k2_db", int'(o_data_byte), 8'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
